piccolo_iter_core: RTL and testbench
====================================

# piccolo_iter_core

Parametrised iterative Piccolo block-cipher encryption core. It supports both Piccolo-80 (25 rounds) and Piccolo-128 (31 rounds), selected per block. A compile-time number of rounds is unrolled per clock. The core accepts plaintext and key through a valid/ready handshake and returns the ciphertext through a valid/ready handshake. It is the successor to the fixed-key, fixed-unroll Piccolo datapath, and sits between the team's block-mode wrappers and the test harness.

## Interface
- UNROLL, 1, rounds computed per clock; legal range 1..8. The last cycle may use fewer rounds.
- clk  in  1  rising-edge clock
- reset  in  1  reset reset, synchronous, active-high
- in_valid  in  1  plaintext/key/mode present
- in_ready  out  1  core can accept a block
- in_k128  in  1  1 = Piccolo-128, 0 = Piccolo-80
- in_key  in  128  key, bit 127 = first key bit. Piccolo-80 uses in_key[127:48]; in_key[47:0] are ignored.
- in_data  in  64  plaintext, bit 63 = first bit
- out_valid  out  1  ciphertext available
- out_ready  in  1  consumer accepts ciphertext
- out_data  out  64  ciphertext, bit 63 = first bit

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready = 1. On in_valid & in_ready:
  - latch in_k128 into mode_q and the key into key_q.
  - load state_q = in_data with input whitening (X0 ^= wk0, X2 ^= wk1).
  - clear round counter rnd_q = 0; go to RUN.
- Inputs are sampled only on the accept edge. Later changes to in_* do not affect the block in flight.
- Round count: R = 31 if mode_q else 25.
- RUN: each cycle applies UNROLL chained round slices to state_q.
  - Slice j (round index rnd_q+j) is active only when rnd_q+j < R. Inactive slices pass data through unchanged.
  - Each round: F-functions (S-box → diffusion matrix over GF(2^4) with polynomial x^4+x+1 → S-box) on X0 and X2. XOR results into X1 and X3, then add rk_{2i} and rk_{2i+1}.
  - The round permutation is applied after every round except round R-1.
  - rnd_q += UNROLL, saturating at R.
  - When the last round completes, register out_data = state after output whitening (X0 ^= wk2, X2 ^= wk3); go to DONE.
- Round keys: generated combinationally from key_q and the absolute round index, per the Piccolo specification.
  - Key words k_i are 16 bits, k0 = key_q[127:112].
  - 80-bit: round constants use 0x0f1e2d3c and the i mod 5 selection of k0..k4.
  - 128-bit: round constants use 0x6547a98b and the k_{(j+2) mod 8} indexing with the permutation every 8 round-key words.
  - No running key register. Every round index is independently computable, which is what makes UNROLL legal.
- Whitening keys:
  - wk0 = {k0[15:8], k1[7:0]}, wk1 = {k1[15:8], k0[7:0]}.
  - 80-bit: wk2 = {k4[15:8], k3[7:0]}, wk3 = {k3[15:8], k4[7:0]}.
  - 128-bit: wk2 = {k4[15:8], k7[7:0]}, wk3 = {k7[15:8], k4[7:0]}.
- DONE: out_valid = 1 and out_data is held stable until out_ready. On out_valid & out_ready, go to IDLE.
- in_ready = 1 only in IDLE. There is no overlap of blocks.

## Timing
- Reset values: state IDLE, in_ready = 1, out_valid = 0, out_data = 0, rnd_q = 0, state_q = 0.
- Reset asserted in any state aborts the block in flight. The next edge gives the reset values, and no ciphertext is emitted.
- RUN cycles: C = ceil(R / UNROLL).
  - UNROLL=1: 25 / 31.
  - UNROLL=4: 7 / 8.
  - UNROLL=5: 5 / 7.
  - UNROLL=8: 4 / 4.
- Latency: accept edge at cycle t, out_valid high from cycle t+C+1.
- Throughput: one block per C+2 cycles when out_ready is held high (accept, C RUN cycles, DONE with same-cycle handshake).
- out_valid with out_ready low: the core stalls in DONE indefinitely. in_ready stays 0.
- Simultaneous in_valid and DONE handshake: not accepted in the same cycle. The new block is accepted the cycle after, in IDLE.
- Critical path: UNROLL chained rounds. UNROLL > 8 is rejected at elaboration.

## Test plan
- Piccolo-80, UNROLL=1: key 0x00112233445566778899 in in_key[127:48], in_data 0x0123456789abcdef → out_data 0x8d2bff9935f84056, out_valid exactly 26 cycles after the accept edge.
- Piccolo-128, UNROLL=1 and 4: key 0x00112233445566778899aabbccddeeff, in_data 0x0123456789abcdef → the published Piccolo-128 vector. out_valid at 32 and 9 cycles respectively; both builds produce identical out_data.
- Non-dividing unroll: UNROLL=4 Piccolo-80 and UNROLL=8 Piccolo-128 with random keys and data → match the software model over 1000 blocks, including back-to-back mixed modes.
- Backpressure: hold out_ready = 0 for 20 cycles in DONE → out_data stable, in_ready = 0, in_valid ignored. Release → one handshake, then in_ready = 1 on the next cycle.
- Input isolation: change in_key, in_data and in_k128 every cycle during RUN → ciphertext matches the values sampled at accept.
- Reset mid-RUN (cycle 10 of 25) → next cycle out_valid = 0, in_ready = 1. A following block then produces the correct ciphertext.

Source files
------------

// File: rtl/piccolo_iter_core.sv
// Iterative Piccolo-80/128 encryption core computing UNROLL rounds per clock.
// Round keys come combinationally from the latched key and the absolute round index.
module piccolo_iter_core #(
    parameter int unsigned UNROLL = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_k128,
    input  logic [127:0] in_key,
    input  logic [63:0]  in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [63:0]  out_data
);

    if (UNROLL < 1 || UNROLL > 8) begin : g_unroll_check
        $error("piccolo_iter_core: UNROLL must be in 1..8");
    end

    // S-box entries packed LSB-first: entry x sits at bits [4x+3:4x].
    localparam logic [63:0] SBOX = 64'hd5c6_f7a1_9083_2b4e;

    typedef enum logic [1:0] {StIdle, StRun, StDone} fsm_e;

    fsm_e         fsm_q;
    logic         mode_q;
    logic [127:0] key_q;
    logic [63:0]  state_q;
    logic [5:0]   rnd_q;
    logic [63:0]  out_data_q;
    logic         in_ready_q;
    logic         out_valid_q;

    function automatic logic [3:0] sbox(input logic [3:0] x);
        return SBOX[4*x +: 4];
    endfunction

    function automatic logic [3:0] gmul2(input logic [3:0] a);
        return {a[2:0], 1'b0} ^ (a[3] ? 4'h3 : 4'h0);
    endfunction

    function automatic logic [15:0] f_func(input logic [15:0] x);
        logic [3:0] s0, s1, s2, s3, y0, y1, y2, y3;
        s0 = sbox(x[15:12]);
        s1 = sbox(x[11:8]);
        s2 = sbox(x[7:4]);
        s3 = sbox(x[3:0]);
        y0 = gmul2(s0) ^ gmul2(s1) ^ s1 ^ s2 ^ s3;
        y1 = s0 ^ gmul2(s1) ^ gmul2(s2) ^ s2 ^ s3;
        y2 = s0 ^ s1 ^ gmul2(s2) ^ gmul2(s3) ^ s3;
        y3 = gmul2(s0) ^ s0 ^ s1 ^ s2 ^ gmul2(s3);
        return {sbox(y0), sbox(y1), sbox(y2), sbox(y3)};
    endfunction

    // Byte permutation (b0..b7) -> (b2, b7, b4, b1, b6, b3, b0, b5).
    function automatic logic [63:0] rp(input logic [63:0] x);
        return {x[47:40], x[7:0], x[31:24], x[55:48], x[15:8], x[39:32], x[63:56], x[23:16]};
    endfunction

    function automatic logic [15:0] kword(input logic [127:0] k, input logic [2:0] i);
        return k[(7 - int'(i)) * 16 +: 16];
    endfunction

    // The 128-bit schedule permutes the key words every 8 round-key words; applying that
    // permutation n times to a slot gives the original key word that now occupies it.
    function automatic logic [2:0] kperm(input logic [2:0] pos, input logic [2:0] n);
        logic [2:0] p;
        p = pos;
        for (int m = 0; m < 7; m++) begin
            if (m < int'(n)) begin
                case (p)
                    3'd0:    p = 3'd2;
                    3'd1:    p = 3'd1;
                    3'd2:    p = 3'd6;
                    3'd3:    p = 3'd7;
                    3'd4:    p = 3'd0;
                    3'd5:    p = 3'd3;
                    3'd6:    p = 3'd4;
                    default: p = 3'd5;
                endcase
            end
        end
        return p;
    endfunction

    function automatic logic [31:0] round_con(input logic k128, input logic [5:0] r);
        logic [4:0] c;
        c = 5'(r + 6'd1);
        return {c, 5'd0, c, 2'd0, c, 5'd0, c} ^ (k128 ? 32'h6547a98b : 32'h0f1e2d3c);
    endfunction

    // Returns {rk_2r, rk_2r+1}.
    function automatic logic [31:0] round_key(input logic [127:0] k, input logic k128,
                                              input logic [5:0] r);
        logic [31:0] kk;
        logic [5:0]  t0, t1;
        kk = 32'd0;
        t0 = {r[4:0], 1'b0} + 6'd2;
        t1 = t0 + 6'd1;
        if (k128) begin
            kk = {kword(k, kperm(t0[2:0], t0[5:3])), kword(k, kperm(t1[2:0], t1[5:3]))};
        end else begin
            case (r % 6'd5)
                6'd0, 6'd2: kk = {kword(k, 3'd2), kword(k, 3'd3)};
                6'd1, 6'd4: kk = {kword(k, 3'd0), kword(k, 3'd1)};
                default:    kk = {kword(k, 3'd4), kword(k, 3'd4)};
            endcase
        end
        return kk ^ round_con(k128, r);
    endfunction

    logic [5:0]  rounds;
    logic [63:0] state_d;
    logic [6:0]  rnd_sum;
    logic [5:0]  rnd_d;
    logic        last_run;
    logic [15:0] wk0, wk1, wk2, wk3;
    logic [63:0] cipher;
    logic [63:0] whitened_in;

    assign rounds = mode_q ? 6'd31 : 6'd25;

    always_comb begin : p_rounds
        logic [63:0] st;
        logic [5:0]  r;
        logic [31:0] rk;
        st = state_q;
        r  = 6'd0;
        rk = 32'd0;
        for (int j = 0; j < int'(UNROLL); j++) begin
            r = rnd_q + 6'(j);
            if (r < rounds) begin
                rk = round_key(key_q, mode_q, r);
                st = {st[63:48], st[47:32] ^ f_func(st[63:48]) ^ rk[31:16],
                      st[31:16], st[15:0] ^ f_func(st[31:16]) ^ rk[15:0]};
                if (r != rounds - 6'd1) begin
                    st = rp(st);
                end
            end
        end
        state_d = st;
    end

    assign rnd_sum  = {1'b0, rnd_q} + 7'(UNROLL);
    assign last_run = rnd_sum >= {1'b0, rounds};
    assign rnd_d    = last_run ? rounds : rnd_sum[5:0];

    assign wk0 = {in_key[127:120], in_key[103:96]};
    assign wk1 = {in_key[111:104], in_key[119:112]};
    assign whitened_in = {in_data[63:48] ^ wk0, in_data[47:32], in_data[31:16] ^ wk1,
                          in_data[15:0]};

    always_comb begin
        wk2 = {key_q[63:56], key_q[71:64]};
        wk3 = {key_q[79:72], key_q[55:48]};
        if (mode_q) begin
            wk2 = {key_q[63:56], key_q[7:0]};
            wk3 = {key_q[15:8], key_q[55:48]};
        end
    end

    assign cipher = {state_d[63:48] ^ wk2, state_d[47:32], state_d[31:16] ^ wk3, state_d[15:0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            fsm_q       <= StIdle;
            mode_q      <= 1'b0;
            key_q       <= '0;
            state_q     <= '0;
            rnd_q       <= '0;
            out_data_q  <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            unique case (fsm_q)
                StIdle: begin
                    if (in_valid) begin
                        mode_q     <= in_k128;
                        key_q      <= in_key;
                        state_q    <= whitened_in;
                        rnd_q      <= '0;
                        in_ready_q <= 1'b0;
                        fsm_q      <= StRun;
                    end
                end
                StRun: begin
                    state_q <= state_d;
                    rnd_q   <= rnd_d;
                    if (last_run) begin
                        out_data_q  <= cipher;
                        out_valid_q <= 1'b1;
                        fsm_q       <= StDone;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        fsm_q       <= StIdle;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    fsm_q       <= StIdle;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_piccolo_iter_core.sv
// Scoreboard bench for piccolo_iter_core: a reference Piccolo model predicts each block at accept.
module tb_piccolo_iter_core;

    localparam int unsigned UNROLL = 4;

    localparam logic [3:0] SB [16] = '{4'he, 4'h4, 4'hb, 4'h2, 4'h3, 4'h8, 4'h0, 4'h9,
                                      4'h1, 4'ha, 4'h7, 4'hf, 4'h6, 4'hc, 4'h5, 4'hd};
    localparam logic [3:0] MM [4][4] = '{'{4'd2, 4'd3, 4'd1, 4'd1},
                                         '{4'd1, 4'd2, 4'd3, 4'd1},
                                         '{4'd1, 4'd1, 4'd2, 4'd3},
                                         '{4'd3, 4'd1, 4'd1, 4'd2}};
    localparam int RPT [8] = '{2, 7, 4, 1, 6, 3, 0, 5};

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid, in_ready, in_k128;
    logic [127:0] in_key;
    logic [63:0]  in_data;
    logic         out_valid, out_ready;
    logic [63:0]  out_data;

    typedef struct packed {
        logic [63:0] data;
        logic [31:0] acc;
        logic        k128;
    } exp_t;

    exp_t        exp_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    logic        ov_prev = 1'b0;
    logic        force_exp = 1'b0;
    logic [63:0] force_val = '0;

    piccolo_iter_core #(.UNROLL(UNROLL)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_k128   (in_k128),
        .in_key    (in_key),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] ref_gmul(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] p, aa;
        p  = 4'd0;
        aa = a;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) p ^= aa;
            aa = {aa[2:0], 1'b0} ^ (aa[3] ? 4'b0011 : 4'b0000);
        end
        return p;
    endfunction

    function automatic logic [15:0] ref_f(input logic [15:0] x);
        logic [3:0]  s[4];
        logic [3:0]  y;
        logic [15:0] o;
        o = '0;
        for (int i = 0; i < 4; i++) s[i] = SB[x[15-4*i -: 4]];
        for (int i = 0; i < 4; i++) begin
            y = 4'd0;
            for (int j = 0; j < 4; j++) y ^= ref_gmul(MM[i][j], s[j]);
            o[15-4*i -: 4] = SB[y];
        end
        return o;
    endfunction

    function automatic logic [63:0] ref_rp(input logic [63:0] x);
        logic [63:0] o;
        o = '0;
        for (int i = 0; i < 8; i++) o[63-8*i -: 8] = x[63-8*RPT[i] -: 8];
        return o;
    endfunction

    function automatic logic [63:0] ref_enc(input logic k128, input logic [127:0] key,
                                            input logic [63:0] pt);
        logic [15:0] k[8], tmp[8], rk[62], con[62], x[4], wk[4];
        logic [4:0]  c;
        logic [31:0] cc;
        logic [63:0] s;
        int          nr;
        nr = k128 ? 31 : 25;
        for (int i = 0; i < 8; i++) k[i] = key[127-16*i -: 16];
        wk[0] = {k[0][15:8], k[1][7:0]};
        wk[1] = {k[1][15:8], k[0][7:0]};
        if (k128) begin
            wk[2] = {k[4][15:8], k[7][7:0]};
            wk[3] = {k[7][15:8], k[4][7:0]};
        end else begin
            wk[2] = {k[4][15:8], k[3][7:0]};
            wk[3] = {k[3][15:8], k[4][7:0]};
        end
        for (int i = 0; i < 62; i++) begin
            con[i] = '0;
            rk[i]  = '0;
        end
        for (int i = 0; i < nr; i++) begin
            c  = 5'(i + 1);
            cc = {c, 5'b0, c, 2'b0, c, 5'b0, c} ^ (k128 ? 32'h6547a98b : 32'h0f1e2d3c);
            con[2*i]   = cc[31:16];
            con[2*i+1] = cc[15:0];
        end
        if (!k128) begin
            for (int i = 0; i < nr; i++) begin
                case (i % 5)
                    0, 2: begin rk[2*i] = con[2*i] ^ k[2]; rk[2*i+1] = con[2*i+1] ^ k[3]; end
                    1, 4: begin rk[2*i] = con[2*i] ^ k[0]; rk[2*i+1] = con[2*i+1] ^ k[1]; end
                    default: begin rk[2*i] = con[2*i] ^ k[4]; rk[2*i+1] = con[2*i+1] ^ k[4]; end
                endcase
            end
        end else begin
            for (int i = 0; i < 2*nr; i++) begin
                if ((i + 2) % 8 == 0) begin
                    tmp = k;
                    k[0] = tmp[2]; k[1] = tmp[1]; k[2] = tmp[6]; k[3] = tmp[7];
                    k[4] = tmp[0]; k[5] = tmp[3]; k[6] = tmp[4]; k[7] = tmp[5];
                end
                rk[i] = k[(i + 2) % 8] ^ con[i];
            end
        end
        s = pt;
        s[63:48] ^= wk[0];
        s[31:16] ^= wk[1];
        for (int i = 0; i < nr; i++) begin
            x[0] = s[63:48]; x[1] = s[47:32]; x[2] = s[31:16]; x[3] = s[15:0];
            x[1] ^= ref_f(x[0]) ^ rk[2*i];
            x[3] ^= ref_f(x[2]) ^ rk[2*i+1];
            s = {x[0], x[1], x[2], x[3]};
            if (i != nr - 1) s = ref_rp(s);
        end
        s[63:48] ^= wk[2];
        s[31:16] ^= wk[3];
        return s;
    endfunction

    function automatic int lat_exp(input logic k128);
        int r;
        r = k128 ? 31 : 25;
        return (r + int'(UNROLL) - 1) / int'(UNROLL) + 1;
    endfunction

    // Monitor: predicts at accept, checks latency on out_valid rise and data on handshake.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                exp_q.delete();
                ov_prev = 1'b0;
            end else begin
                if (out_valid && !ov_prev) begin
                    if (exp_q.size() == 0) check_eq("out_unexpected", {63'd0, out_valid}, 64'd0);
                    else check_eq("latency", 64'(cyc - int'(exp_q[0].acc)),
                                  64'(lat_exp(exp_q[0].k128)));
                end
                if (out_valid && out_ready && exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check_eq("cipher", out_data, e.data);
                end
                if (in_valid && in_ready) begin
                    e.data = force_exp ? force_val : ref_enc(in_k128, in_key, in_data);
                    e.acc  = 32'(cyc);
                    e.k128 = in_k128;
                    exp_q.push_back(e);
                end
                ov_prev = out_valid;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_inputs();
        in_k128 = 1'($urandom_range(0, 1));
        in_key  = {$urandom, $urandom, $urandom, $urandom};
        in_data = {$urandom, $urandom};
    endtask

    task automatic send(input logic k128, input logic [127:0] key, input logic [63:0] data);
        logic acc;
        int   g;
        g = 0;
        in_valid = 1'b1;
        in_k128  = k128;
        in_key   = key;
        in_data  = data;
        do begin
            acc = in_ready;
            tick();
            g++;
        end while (!acc && g < 100);
        in_valid = 1'b0;
        check_eq("accept", {63'd0, acc}, 64'd1);
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (exp_q.size() != 0 && g < 200) begin
            tick();
            g++;
        end
        check_eq("drain", 64'(exp_q.size()), 64'd0);
        tick();
    endtask

    localparam logic [127:0] KEY80  = {80'h00112233445566778899, 48'h0};
    localparam logic [127:0] KEY128 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [63:0]  PT     = 64'h0123456789abcdef;
    localparam logic [63:0]  CT80   = 64'h8d2bff9935f84056;

    initial begin : driver
        logic [63:0] held;
        logic        acc;
        int          acc_cnt, guard;
        reset = 1'b1; in_valid = 1'b0; in_k128 = 1'b0; in_key = '0; in_data = '0;
        out_ready = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        check_eq("rst_in_ready", {63'd0, in_ready}, 64'd1);
        check_eq("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check_eq("rst_out_data", out_data, 64'd0);

        // Reference model against the published Piccolo-80 vector.
        check_eq("model_p80", ref_enc(1'b0, KEY80, PT), CT80);

        force_exp = 1'b1;
        force_val = CT80;
        send(1'b0, KEY80 | 128'h0000_0000_0000_0000_0000_dead_beef_cafe, PT);
        force_exp = 1'b0;
        drain();

        send(1'b1, KEY128, PT);
        drain();

        // Input isolation: scramble in_* throughout RUN.
        send(1'b1, {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom});
        repeat (12) begin
            rand_inputs();
            tick();
        end
        drain();

        // Backpressure in DONE with in_valid pushing.
        out_ready = 1'b0;
        send(1'b0, {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom});
        guard = 0;
        while (!out_valid && guard < 50) begin
            tick();
            guard++;
        end
        check_eq("bp_reach_done", {63'd0, out_valid}, 64'd1);
        held = out_data;
        in_valid = 1'b1;
        repeat (20) begin
            rand_inputs();
            tick();
            check_eq("bp_data_stable", out_data, held);
            check_eq("bp_in_ready", {63'd0, in_ready}, 64'd0);
        end
        out_ready = 1'b1;
        tick();
        check_eq("bp_release_ready", {63'd0, in_ready}, 64'd1);
        check_eq("bp_release_valid", {63'd0, out_valid}, 64'd0);
        tick();
        in_valid = 1'b0;
        drain();

        // Reset mid-RUN aborts the block.
        send(1'b0, {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom});
        repeat ((lat_exp(1'b0) - 1) / 2) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_eq("midrst_out_valid", {63'd0, out_valid}, 64'd0);
        check_eq("midrst_in_ready", {63'd0, in_ready}, 64'd1);
        check_eq("midrst_out_data", out_data, 64'd0);
        send(1'b1, {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom});
        drain();

        // Back-to-back mixed modes with random backpressure.
        in_valid = 1'b1;
        rand_inputs();
        acc_cnt = 0;
        guard = 0;
        while (acc_cnt < 300 && guard < 20000) begin
            acc = in_ready;
            tick();
            guard++;
            if (acc) begin
                acc_cnt++;
                rand_inputs();
            end
            out_ready = ($urandom_range(0, 3) != 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        check_eq("b2b_count", 64'(acc_cnt), 64'd300);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
